irq_controller: RTL

//   Interrupt controller that sequences the CPU's interrupt entry (the PCSrc path to 0x80000004).

---
 rtl/irq_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// irq_controller: edge-detecting, priority-arbitrated interrupt controller.
// Holds IER/IPR/ICR on the peripheral bus and sequences one interrupt entry
// at a time through a small IDLE/REQ/SERVICE handshake with the CPU.
module irq_controller #(
  parameter int unsigned NUM_SRC   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0030
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               pc_kernel,
  input  logic               rd,
  input  logic               wr,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               hit,
  output logic               irq_req,
  output logic [2:0]         irq_id
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  // Register word offsets inside the window.
  localparam logic [1:0] OFF_IER  = 2'd0;
  localparam logic [1:0] OFF_IPR  = 2'd1;
  localparam logic [1:0] OFF_ICR  = 2'd2;
  localparam logic [1:0] OFF_ISWR = 2'd3;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_ier;
  logic [NUM_SRC-1:0] r_ipr;
  logic [NUM_SRC-1:0] r_src_d;
  logic [2:0]         r_icr;

  logic [31:0]        w_off;
  logic               w_hit;
  logic [1:0]         w_reg_sel;
  logic               w_wr_ier;
  logic               w_wr_ipr;
  logic               w_wr_iswr;
  logic [NUM_SRC-1:0] w_wmask;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_act;
  logic               w_any_act;
  logic [2:0]         w_sel;
  logic [NUM_SRC-1:0] w_sel_onehot;
  logic               w_take;
  logic [NUM_SRC-1:0] w_take_mask;
  logic [NUM_SRC-1:0] w_ipr_clr;
  logic [NUM_SRC-1:0] w_ipr_set;
  logic [NUM_SRC-1:0] w_ipr_nxt;
  logic [31:0]        w_rdata;
  logic               w_unused_wdata;

  // Address decode: offset from base must be 0x0..0xC and word aligned.
  assign w_off     = addr - BASE_ADDR;
  assign w_hit     = (w_off[31:4] == '0) && (w_off[1:0] == 2'b00);
  assign w_reg_sel = w_off[3:2];
  assign w_wmask   = wdata[NUM_SRC-1:0];

  assign w_wr_ier  = wr && w_hit && (w_reg_sel == OFF_IER);
  assign w_wr_ipr  = wr && w_hit && (w_reg_sel == OFF_IPR);
  assign w_wr_iswr = wr && w_hit && (w_reg_sel == OFF_ISWR);

  // Only the low NUM_SRC data bits carry meaning for any register.
  assign w_unused_wdata = ^wdata[31:NUM_SRC];

  assign w_rise    = src_irq & ~r_src_d;
  assign w_act     = r_ipr & r_ier;
  assign w_any_act = |w_act;

  // Fixed-priority pick: lowest pending+enabled index wins.
  always_comb begin
    w_sel        = '0;
    w_sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_act[i] && (w_sel_onehot == '0)) begin
        w_sel           = 3'(i);
        w_sel_onehot[i] = 1'b1;
      end
    end
  end

  // Entry handshake next-state; w_take marks the edge the CPU accepts the IRQ.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_act && !pc_kernel) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (!w_any_act || pc_kernel) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_SERVICE;
          w_take      = 1'b1;
        end
      end
      S_SERVICE: begin
        if (!pc_kernel) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pending update: clears applied first, sets OR'd last so a same-edge set wins.
  always_comb begin
    w_take_mask = w_take ? w_sel_onehot : '0;
    w_ipr_clr   = (w_wr_ipr ? w_wmask : '0) | w_take_mask;
    w_ipr_set   = w_rise | (w_wr_iswr ? w_wmask : '0);
    w_ipr_nxt   = (r_ipr & ~w_ipr_clr) | w_ipr_set;
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Source history, enable, pending and cause registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src_d <= '0;
      r_ier   <= '0;
      r_ipr   <= '0;
      r_icr   <= '0;
    end else begin
      r_src_d <= src_irq;
      r_ipr   <= w_ipr_nxt;
      if (w_wr_ier) r_ier <= w_wmask;
      if (w_take)   r_icr <= w_sel;
    end
  end

  // Combinational read mux; ISWR is write-only and reads zero.
  always_comb begin
    w_rdata = '0;
    if (rd && w_hit) begin
      case (w_reg_sel)
        OFF_IER:  w_rdata = {{(32-NUM_SRC){1'b0}}, r_ier};
        OFF_IPR:  w_rdata = {{(32-NUM_SRC){1'b0}}, r_ipr};
        OFF_ICR:  w_rdata = {29'b0, r_icr};
        OFF_ISWR: w_rdata = '0;
        default:  w_rdata = '0;
      endcase
    end
  end

  assign rdata   = w_rdata;
  assign hit     = w_hit;
  assign irq_req = (r_state == S_REQ);
  assign irq_id  = r_icr;

endmodule
